// File: rtl/array_reducer.sv
`default_nettype none
// ============================================================================
//  Module   : array_reducer
//  Purpose  : Streaming reduction engine. A start pulse opens a frame of
//             exactly NUM_ELEMS samples taken over a valid/ready input. The
//             frame reduces to one result (sum, min or max, chosen per frame
//             by op). The result is held on a valid/ready output until it is
//             consumed.
//  Ports    : clk, reset      - clock and synchronous active-high reset
//             start, op       - frame start and operation (00 sum, 01 min,
//                               10 max, 11 sum), sampled in IDLE only
//             clear           - synchronous abort of the current frame
//             in_data/valid/ready   - sample input handshake
//             out_result/overflow/valid/ready - result output handshake
//             busy            - high while accumulating or holding a result
//             beat_count      - samples accepted in the current frame
//  Revision : 1.0 - initial release
// ============================================================================
module array_reducer #(
  parameter int DATA_W    = 8,
  parameter int NUM_ELEMS = 5,
  parameter int SUM_W     = 16,
  parameter int SIGNED    = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [1:0]                       op,
  input  logic                             clear,
  input  logic [DATA_W-1:0]                in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [SUM_W-1:0]                 out_result,
  output logic                             out_overflow,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             busy,
  output logic [$clog2(NUM_ELEMS+1)-1:0]   beat_count
);

  localparam int CNT_W = $clog2(NUM_ELEMS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_ELEMS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [1:0]       op_q;
  logic [SUM_W-1:0] acc;
  logic             acc_ovf;

  // Sample widened to the accumulator width.
  logic [SUM_W-1:0] sample_ext;

  generate
    if (SUM_W == DATA_W) begin : g_no_ext
      assign sample_ext = in_data;
    end else if (SIGNED != 0) begin : g_sign_ext
      assign sample_ext = {{(SUM_W-DATA_W){in_data[DATA_W-1]}}, in_data};
    end else begin : g_zero_ext
      assign sample_ext = {{(SUM_W-DATA_W){1'b0}}, in_data};
    end
  endgenerate

  // One extra bit keeps the carry out of the unsigned add.
  logic [SUM_W:0]   sum_full;
  logic             sum_ovf;
  logic             sample_less;
  logic             sample_greater;
  logic             first_beat;
  logic             last_beat;
  logic             beat;
  logic [SUM_W-1:0] acc_next;
  logic             ovf_next;

  assign sum_full   = {1'b0, acc} + {1'b0, sample_ext};
  assign first_beat = (beat_count == '0);
  assign last_beat  = (beat_count == LAST_CNT);
  assign beat       = in_valid && in_ready;

  always_comb begin
    sum_ovf        = 1'b0;
    sample_less    = 1'b0;
    sample_greater = 1'b0;
    if (SIGNED != 0) begin
      // Signed overflow: like-signed operands whose sum changes sign.
      sum_ovf        = (acc[SUM_W-1] == sample_ext[SUM_W-1]) &&
                       (sum_full[SUM_W-1] != acc[SUM_W-1]);
      sample_less    = $signed(sample_ext) < $signed(acc);
      sample_greater = $signed(sample_ext) > $signed(acc);
    end else begin
      sum_ovf        = sum_full[SUM_W];
      sample_less    = sample_ext < acc;
      sample_greater = sample_ext > acc;
    end
  end

  always_comb begin
    acc_next = acc;
    ovf_next = acc_ovf;
    case (op_q)
      2'b01: begin
        // The first beat always loads; later beats replace only when strictly smaller.
        if (first_beat || sample_less) acc_next = sample_ext;
      end
      2'b10: begin
        if (first_beat || sample_greater) acc_next = sample_ext;
      end
      default: begin
        acc_next = sum_full[SUM_W-1:0];
        ovf_next = acc_ovf | sum_ovf;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      op_q         <= 2'b00;
      acc          <= '0;
      acc_ovf      <= 1'b0;
      beat_count   <= '0;
      in_ready     <= 1'b0;
      busy         <= 1'b0;
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_overflow <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q       <= op;
            acc        <= '0;
            acc_ovf    <= 1'b0;
            beat_count <= '0;
            in_ready   <= 1'b1;
            busy       <= 1'b1;
            state      <= S_ACCUM;
          end
        end

        S_ACCUM: begin
          if (clear) begin
            // Abort wins over a same-cycle beat, including the final one.
            state      <= S_IDLE;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            out_valid  <= 1'b0;
            beat_count <= '0;
            acc        <= '0;
            acc_ovf    <= 1'b0;
          end else if (beat) begin
            acc        <= acc_next;
            acc_ovf    <= ovf_next;
            beat_count <= beat_count + CNT_W'(1);
            if (last_beat) begin
              state        <= S_DONE;
              in_ready     <= 1'b0;
              out_valid    <= 1'b1;
              out_result   <= acc_next;
              out_overflow <= ovf_next;
            end
          end
        end

        S_DONE: begin
          if (clear) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            out_valid  <= 1'b0;
            beat_count <= '0;
            acc        <= '0;
            acc_ovf    <= 1'b0;
          end else if (out_ready) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
          end
        end

        default: begin
          state     <= S_IDLE;
          in_ready  <= 1'b0;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_array_reducer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_array_reducer
//  Purpose  : Self-checking bench for array_reducer. Three instances share
//             one stimulus stream: default unsigned/16-bit, signed/16-bit and
//             unsigned/8-bit. Each is compared with an arithmetic reference
//             model of the reduction.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_array_reducer;

  localparam int N = 5;

  logic       clk = 1'b0;
  logic       reset, start, clear, in_valid, out_ready;
  logic [1:0] op;
  logic [7:0] in_data;

  logic        rdy_a, rdy_b, rdy_c;
  logic [15:0] res_a, res_b;
  logic [7:0]  res_c;
  logic        ovf_a, ovf_b, ovf_c;
  logic        val_a, val_b, val_c;
  logic        busy_a, busy_b, busy_c;
  logic [2:0]  cnt_a, cnt_b, cnt_c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  array_reducer #(.DATA_W(8), .NUM_ELEMS(N), .SUM_W(16), .SIGNED(0)) u_def (
    .clk(clk), .reset(reset), .start(start), .op(op), .clear(clear),
    .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_a),
    .out_result(res_a), .out_overflow(ovf_a), .out_valid(val_a),
    .out_ready(out_ready), .busy(busy_a), .beat_count(cnt_a));

  array_reducer #(.DATA_W(8), .NUM_ELEMS(N), .SUM_W(16), .SIGNED(1)) u_sgn (
    .clk(clk), .reset(reset), .start(start), .op(op), .clear(clear),
    .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_b),
    .out_result(res_b), .out_overflow(ovf_b), .out_valid(val_b),
    .out_ready(out_ready), .busy(busy_b), .beat_count(cnt_b));

  array_reducer #(.DATA_W(8), .NUM_ELEMS(N), .SUM_W(8), .SIGNED(0)) u_nar (
    .clk(clk), .reset(reset), .start(start), .op(op), .clear(clear),
    .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_c),
    .out_result(res_c), .out_overflow(ovf_c), .out_valid(val_c),
    .out_ready(out_ready), .busy(busy_c), .beat_count(cnt_c));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reduction computed on plain integers: samples are read as signed or
  // unsigned numbers, the running sum is kept in range by wrapping, and any
  // step leaving the representable range marks overflow.
  function automatic void model(input int fop, input int sw, input bit sgn,
                                input byte unsigned s[N],
                                output logic [15:0] res, output bit ovf);
    longint span, lo, hi, r, t, v;
    span = longint'(1) << sw;
    lo   = sgn ? -(span / 2) : 0;
    hi   = sgn ? (span / 2) - 1 : span - 1;
    ovf  = 1'b0;
    r    = 0;
    for (int i = 0; i < N; i++) begin
      v = sgn ? longint'(byte'(s[i])) : longint'(s[i]);
      if (fop == 1) begin
        if (i == 0 || v < r) r = v;
      end else if (fop == 2) begin
        if (i == 0 || v > r) r = v;
      end else begin
        t = r + v;
        if (t < lo || t > hi) ovf = 1'b1;
        if (t > hi) t -= span;
        if (t < lo) t += span;
        r = t;
      end
    end
    res = 16'(r & (span - 1));
  endfunction

  task automatic run_frame(input logic [1:0] fop, input byte unsigned s[N],
                           input int gap_pct, input int bp_cycles);
    logic [15:0] ea, eb, ec;
    bit          oa, ob, oc;
    model(int'(fop), 16, 1'b0, s, ea, oa);
    model(int'(fop), 16, 1'b1, s, eb, ob);
    model(int'(fop), 8,  1'b0, s, ec, oc);

    check_eq("idle_in_ready", 32'(rdy_a), 0);
    check_eq("idle_busy", 32'(busy_a), 0);
    start = 1'b1;
    op    = fop;
    @(negedge clk);
    start = 1'b0;
    op    = 2'($urandom);
    check_eq("accum_busy", 32'(busy_a), 1);
    check_eq("accum_cnt0", 32'(cnt_a), 0);

    for (int i = 0; i < N; i++) begin
      while ($urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        @(negedge clk);
        check_eq("gap_in_ready", 32'(rdy_a), 1);
        check_eq("gap_cnt", 32'(cnt_a), 32'(i));
      end
      in_valid = 1'b1;
      in_data  = s[i];
      if (i == N - 1) check_eq("early_valid", 32'(val_a), 0);
      @(negedge clk);
    end
    in_valid = 1'b0;

    check_eq("valid_a", 32'(val_a), 1);
    check_eq("valid_b", 32'(val_b), 1);
    check_eq("valid_c", 32'(val_c), 1);
    check_eq("res_a", 32'(res_a), 32'(ea));
    check_eq("res_b", 32'(res_b), 32'(eb));
    check_eq("res_c", 32'(res_c), 32'(ec));
    check_eq("ovf_a", 32'(ovf_a), 32'(oa));
    check_eq("ovf_b", 32'(ovf_b), 32'(ob));
    check_eq("ovf_c", 32'(ovf_c), 32'(oc));
    check_eq("done_cnt", 32'(cnt_a), N);
    check_eq("done_in_ready", 32'(rdy_a), 0);

    // Hold the result under backpressure while start toggles.
    for (int k = 0; k < bp_cycles; k++) begin
      start     = 1'($urandom);
      out_ready = 1'b0;
      @(negedge clk);
      check_eq("bp_valid", 32'(val_a), 1);
      check_eq("bp_res_b", 32'(res_b), 32'(eb));
      check_eq("bp_ovf_c", 32'(ovf_c), 32'(oc));
      check_eq("bp_in_ready", 32'(rdy_a), 0);
      check_eq("bp_cnt", 32'(cnt_c), N);
    end

    // Handshake with start asserted in the same cycle: start is ignored.
    out_ready = 1'b1;
    start     = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    start     = 1'b0;
    check_eq("post_valid", 32'(val_a), 0);
    check_eq("post_busy", 32'(busy_b), 0);
    @(negedge clk);
    check_eq("post_idle", 32'(busy_a), 0);
  endtask

  // Abort a frame after n_beats beats, using clear or reset in a cycle
  // that also presents one more beat.
  task automatic abort_frame(input int n_beats, input bit use_reset);
    start = 1'b1;
    op    = 2'b00;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < n_beats; i++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      @(negedge clk);
    end
    check_eq("pre_abort_cnt", 32'(cnt_a), 32'(n_beats));
    in_valid = 1'b1;
    in_data  = 8'($urandom);
    if (use_reset) reset = 1'b1;
    else           clear = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    clear    = 1'b0;
    in_valid = 1'b0;
    check_eq("abort_valid", 32'(val_a), 0);
    check_eq("abort_busy", 32'(busy_a), 0);
    check_eq("abort_cnt", 32'(cnt_a), 0);
    check_eq("abort_in_ready", 32'(rdy_a), 0);
    if (use_reset) begin
      check_eq("rst_res_a", 32'(res_a), 0);
      check_eq("rst_res_c", 32'(res_c), 0);
      check_eq("rst_ovf_c", 32'(ovf_c), 0);
    end
    @(negedge clk);
    check_eq("abort_no_result", 32'(val_b), 0);
  endtask

  initial begin
    byte unsigned f[N];

    reset = 1'b1; start = 1'b0; clear = 1'b0; in_valid = 1'b0;
    out_ready = 1'b0; op = 2'b00; in_data = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_eq("rst_valid", 32'(val_a), 0);
    check_eq("rst_in_ready", 32'(rdy_a), 0);
    check_eq("rst_busy", 32'(busy_a), 0);
    check_eq("rst_ovf", 32'(ovf_a), 0);
    check_eq("rst_result", 32'(res_b), 0);
    check_eq("rst_cnt", 32'(cnt_a), 0);

    // clear in IDLE is a no-op
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check_eq("idle_clear", 32'(busy_a), 0);

    f = '{10, 20, 30, 40, 50};         run_frame(2'b00, f, 0, 0);
    f = '{7, 3, 200, 3, 9};            run_frame(2'b01, f, 40, 1);
                                       run_frame(2'b10, f, 40, 0);
    f = '{8'h80, 8'h7F, 8'hFF, 8'h05, 8'h01};
                                       run_frame(2'b00, f, 0, 0);
                                       run_frame(2'b01, f, 20, 0);
                                       run_frame(2'b10, f, 20, 0);
    f = '{200, 100, 0, 0, 0};          run_frame(2'b00, f, 0, 4);
    f = '{1, 1, 1, 1, 1};              run_frame(2'b11, f, 0, 0);

    abort_frame(3, 1'b0);
    f = '{1, 2, 3, 4, 5};              run_frame(2'b00, f, 0, 0);
    abort_frame(N - 1, 1'b0);          // clear beats the final beat
    abort_frame(3, 1'b1);
    f = '{255, 255, 255, 255, 255};    run_frame(2'b00, f, 10, 0);

    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < N; i++) f[i] = 8'($urandom);
      run_frame(2'($urandom), f, $urandom_range(50), $urandom_range(3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/array_reducer.md
Name: array_reducer

Overview:
- Parametrised streaming reduction engine. After a start pulse, accepts exactly NUM_ELEMS samples over a valid/ready input and produces one result: sum, minimum or maximum, selected per frame.
- Result is held on a valid/ready output until consumed. Sum mode adds signed/unsigned handling and an overflow flag.
- Sits between a sample source (ADC or buffer reader) and a downstream consumer in the datapath.

Parameters:
- DATA_W, 8, input sample width in bits.
- NUM_ELEMS, 5, samples per frame. Must be >= 1.
- SUM_W, 16, result width in bits. Must be >= DATA_W.
- SIGNED, 0. 0 = samples and result unsigned; 1 = two's complement.

Ports:
- clk  in  1  single clock; everything updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a frame. Sampled only in IDLE.
- op  in  2  operation, latched with start: 00 sum, 01 min, 10 max, 11 reserved (treated as sum).
- clear  in  1  synchronous abort of the current frame.
- in_data  in  DATA_W  input sample.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts a sample this cycle.
- out_result  out  SUM_W  reduction result.
- out_overflow  out  1  sum overflowed during this frame.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- busy  out  1  high in ACCUM and DONE.
- beat_count  out  $clog2(NUM_ELEMS+1)  samples accepted in the current frame.

Behaviour:
- Reset: state=IDLE. in_ready, out_valid, out_overflow and busy = 0. out_result, beat_count and the internal accumulator = 0. Reset overrides all other inputs, in any state.
- State IDLE:
  - in_ready=0, busy=0.
  - start=1: latch op, clear accumulator, beat_count and overflow, then go to ACCUM.
  - clear in IDLE has no effect.
- State ACCUM:
  - in_ready=1.
  - A beat is in_valid && in_ready. Each beat increments beat_count.
  - in_valid gaps are allowed and do not change state.
  - Sum: accumulator += in_data, extended to SUM_W (zero-extended if SIGNED=0, sign-extended if SIGNED=1). Wraps modulo 2^SUM_W.
  - Min/max: the first beat loads the accumulator. Later beats replace it if the new sample is strictly smaller (min) or strictly larger (max). Compare is signed when SIGNED=1.
  - Overflow (sum only), sticky within the frame:
    - SIGNED=0: carry out of bit SUM_W-1.
    - SIGNED=1: both operands have the same sign and the result sign differs.
    - Min/max: overflow is always 0.
  - On the beat where beat_count reaches NUM_ELEMS: go to DONE. out_result and out_overflow are registered from the final accumulator value. out_valid rises exactly 1 cycle after the final beat is accepted.
- State DONE:
  - in_ready=0.
  - out_valid=1. out_result, out_overflow and beat_count (= NUM_ELEMS) are held stable until out_ready.
  - out_valid && out_ready: next cycle out_valid=0 and state returns to IDLE.
  - start asserted during DONE, including the handshake cycle, is ignored.
- clear in ACCUM or DONE:
  - Next cycle: IDLE, out_valid=0, beat_count=0, accumulator=0.
  - No result is emitted. A beat presented in the same cycle is discarded.
  - clear takes priority over a same-cycle final beat or output handshake.
- Widths: beat_count never exceeds NUM_ELEMS. With NUM_ELEMS=1, the single beat moves straight to DONE.
- out_result holds its last value in IDLE. Consumers must qualify it with out_valid.

Test Plan:
- Defaults, op=sum, samples 10,20,30,40,50 on back-to-back beats → out_valid 1 cycle after the 5th beat; out_result=150, out_overflow=0, beat_count=5.
- op=min with in_valid gaps, samples 7,3,200,3,9 → out_result=3. Repeat with op=max → out_result=200. in_ready is low outside ACCUM.
- SIGNED=1, op=sum, samples 0x80,0x7F,0xFF,0x05,0x01 → out_result=16'h0004. op=min on the same samples → 16'hFF80. op=max → 16'h007F.
- SUM_W=8, SIGNED=0, sum, samples 200,100,0,0,0 → out_result=44, out_overflow=1. The next frame 1,1,1,1,1 → 5 with overflow=0.
- Backpressure: hold out_ready=0 for 4 cycles after out_valid and pulse start meanwhile → result, overflow and in_ready=0 stay stable and start is ignored. out_ready=1 → IDLE next cycle.
- After 3 beats, assert clear → IDLE, no out_valid, and a new frame sums correctly from 0. Separately, assert reset after 3 beats → all outputs zero next cycle.
